// File: rtl/button_event_decoder.sv
// Classifies the debounced button level into short-press, long-press and double-click pulses.
// Latency: each event pulse is registered and appears one cycle after the edge that decides it.
// Backpressure: none; the events are fire-and-forget pulses and the FSM always advances.
module button_event_decoder #(
    parameter int unsigned        CNT_W      = 32,
    parameter logic [CNT_W-1:0]   LONG_TICKS = 50_000_000,
    parameter logic [CNT_W-1:0]   GAP_TICKS  = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clean,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        WAIT2  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = LONG_TICKS - 1'b1;
    localparam logic [CNT_W-1:0] GAP_LAST  = GAP_TICKS - 1'b1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             clean_d;
    logic             rise;

    assign rise = clean & ~clean_d;
    assign busy = (state != IDLE);

    // clean_d resets high so a button held across reset must be released before it counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            clean_d      <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            clean_d      <= clean;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    // A release on the terminal edge takes precedence over the long press.
                    if (!clean) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= HOLD;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT2: begin
                    // A press on the terminal edge still counts as the second click.
                    if (clean) begin
                        double_click <= 1'b1;
                        state        <= HOLD;
                        cnt          <= '0;
                    end else if (cnt == GAP_LAST) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!clean) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
